udl_counter_sweep_ctrl: RTL and testbench

- Sequencer for the N-bit up/down/loadable counter. It drives the counter's enable, up, load and L inputs to run programmed sweeps: preload a start value, then step toward an end value at a programmable rate, up, down or bouncing.
- It keeps an internal shadow of the counter position and checks it against the counter's Q output every run cycle.
- It sits between a host/config interface (start/busy/done) and one counter instance.

---
 rtl/udl_counter_sweep_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_udl_counter_sweep_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udl_counter_sweep_ctrl.sv
// Sweep sequencer for an N-bit up/down/loadable counter: preloads a start value, steps toward
// an end value at a divided rate (up, down or bounce), repeats passes and cross-checks Q.
module udl_counter_sweep_ctrl #(
  parameter int N  = 4,
  parameter int PW = 8,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  start_val,
  input  logic [N-1:0]  end_val,
  input  logic [PW-1:0] div,
  input  logic [RW-1:0] repeats,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [RW-1:0] pass_cnt,
  output logic          cnt_enable,
  output logic          cnt_up,
  output logic          cnt_load,
  output logic [N-1:0]  cnt_L,
  input  logic [N-1:0]  cnt_q
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [N-1:0]  ONE_N  = N'(1);
  localparam logic [PW-1:0] ONE_PW = PW'(1);
  localparam logic [RW-1:0] ONE_RW = RW'(1);

  state_t        state_r, state_s;
  logic [1:0]    mode_r, mode_s;
  logic [N-1:0]  start_r, start_s, end_r, end_s;
  logic [N-1:0]  pos_r, pos_s, tgt_s;
  logic [PW-1:0] div_r, div_s, gap_r, gap_s;
  logic [RW-1:0] rep_r, rep_s, pass_cnt_s;
  logic          ret_r, ret_s, fin_r, fin_s, last_r, last_s;
  logic          eval_s, bounce_s, last_pass_s;
  logic          busy_s, done_s, err_s, cnt_enable_s, cnt_up_s, cnt_load_s;
  logic [N-1:0]  cnt_L_s;

  // Next-state and next-output logic; every decision looks at the position after this edge
  always_comb begin
    state_s     = state_r;
    mode_s      = mode_r;
    start_s     = start_r;
    end_s       = end_r;
    div_s       = div_r;
    rep_s       = rep_r;
    gap_s       = gap_r;
    ret_s       = ret_r;
    fin_s       = 1'b0;
    last_s      = last_r;
    err_s       = err;
    pass_cnt_s  = pass_cnt;
    cnt_up_s    = cnt_up;
    cnt_L_s     = cnt_L;
    eval_s      = 1'b0;
    tgt_s       = end_r;
    bounce_s    = (mode_r == 2'b10);
    last_pass_s = (pass_cnt >= rep_r);

    if (cnt_enable) begin
      pos_s = cnt_up ? (pos_r + ONE_N) : (pos_r - ONE_N);
    end else begin
      pos_s = pos_r;
    end

    case (state_r)
      S_IDLE: begin
        if (start && !abort) begin
          mode_s     = mode;
          start_s    = start_val;
          end_s      = end_val;
          div_s      = div;
          rep_s      = repeats;
          err_s      = 1'b0;
          pass_cnt_s = '0;
          cnt_L_s    = start_val;
          last_s     = 1'b0;
          state_s    = S_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_s = S_IDLE;
        end else begin
          pos_s    = start_r;
          cnt_up_s = (mode_r != 2'b01);
          ret_s    = 1'b0;
          gap_s    = '0;
          eval_s   = 1'b1;
          state_s  = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (cnt_q != pos_r) begin
          err_s   = 1'b1;
          state_s = S_DONE;
        end else if (fin_r) begin
          state_s = last_r ? S_DONE : S_LOAD;
        end else begin
          if (cnt_enable) begin
            gap_s = div_r;
          end else if (gap_r != '0) begin
            gap_s = gap_r - ONE_PW;
          end else begin
            gap_s = '0;
          end
          eval_s = 1'b1;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // Arrival handling: bounce turns at end_val, passes complete at the leg target
    if (eval_s) begin
      tgt_s = ret_s ? start_r : end_r;
      if (pos_s == tgt_s) begin
        if (bounce_s && !ret_s && (start_r != end_r)) begin
          ret_s    = 1'b1;
          cnt_up_s = ~cnt_up_s;
        end else begin
          pass_cnt_s = pass_cnt + ONE_RW;
          if (bounce_s && !last_pass_s) begin
            ret_s    = 1'b0;
            cnt_up_s = 1'b1;
          end else begin
            fin_s  = 1'b1;
            last_s = last_pass_s;
          end
        end
      end else begin
        fin_s = 1'b0;
      end
      tgt_s        = ret_s ? start_r : end_r;
      cnt_enable_s = !fin_s && (gap_s == '0) && (pos_s != tgt_s);
    end else begin
      cnt_enable_s = (state_s == S_LOAD);
    end

    busy_s     = (state_s == S_LOAD) || (state_s == S_RUN);
    done_s     = (state_s == S_DONE);
    cnt_load_s = (state_s == S_LOAD);
  end

  // State, configuration, shadow position and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      mode_r     <= 2'b00;
      start_r    <= '0;
      end_r      <= '0;
      div_r      <= '0;
      rep_r      <= '0;
      pos_r      <= '0;
      gap_r      <= '0;
      ret_r      <= 1'b0;
      fin_r      <= 1'b0;
      last_r     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      pass_cnt   <= '0;
      cnt_enable <= 1'b0;
      cnt_up     <= 1'b0;
      cnt_load   <= 1'b0;
      cnt_L      <= '0;
    end else begin
      state_r    <= state_s;
      mode_r     <= mode_s;
      start_r    <= start_s;
      end_r      <= end_s;
      div_r      <= div_s;
      rep_r      <= rep_s;
      pos_r      <= pos_s;
      gap_r      <= gap_s;
      ret_r      <= ret_s;
      fin_r      <= fin_s;
      last_r     <= last_s;
      busy       <= busy_s;
      done       <= done_s;
      err        <= err_s;
      pass_cnt   <= pass_cnt_s;
      cnt_enable <= cnt_enable_s;
      cnt_up     <= cnt_up_s;
      cnt_load   <= cnt_load_s;
      cnt_L      <= cnt_L_s;
    end
  end

endmodule

// File: tb/tb_udl_counter_sweep_ctrl.sv
// Bench for udl_counter_sweep_ctrl: a counter model closes the loop, a sweep-level model fills
// a scoreboard of expected load/step/done events, and directed checks cover abort, Q error, reset.
module tb_udl_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort;
  logic [1:0] mode;
  logic [3:0] start_val, end_val, repeats;
  logic [7:0] div;
  logic       busy, done, err, cnt_enable, cnt_up, cnt_load;
  logic [3:0] pass_cnt, cnt_L, cnt_q, q_model, q_flip;

  typedef struct {
    int kind;  // 0 load, 1 step, 2 done
    int val;   // load: L, step: Q before the step, done: pass_cnt
    int up;
    int q;     // done: final Q
    int gap;   // cycles since previous event, -1 = unchecked
  } ev_t;

  ev_t sbq[$];
  int  total = 0;
  int  bad = 0;
  bit  sb_on = 1'b0;
  int  cyc = 0;
  int  last_cyc = 0;

  udl_counter_sweep_ctrl #(.N(4), .PW(8), .RW(4)) dut (
    .clk(clk), .reset(rst), .start(start), .abort(abort), .mode(mode),
    .start_val(start_val), .end_val(end_val), .div(div), .repeats(repeats),
    .busy(busy), .done(done), .err(err), .pass_cnt(pass_cnt),
    .cnt_enable(cnt_enable), .cnt_up(cnt_up), .cnt_load(cnt_load),
    .cnt_L(cnt_L), .cnt_q(cnt_q)
  );

  always #5 clk = ~clk;

  // Behavioural up/down/loadable counter driven by the sequencer
  always @(posedge clk or posedge rst) begin
    if (rst) q_model <= 4'd0;
    else if (cnt_enable) begin
      if (cnt_load) q_model <= cnt_L;
      else if (cnt_up) q_model <= q_model + 4'd1;
      else q_model <= q_model - 4'd1;
    end
  end
  assign cnt_q = q_model ^ q_flip;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input int val, input int up, input int q, input int gap);
    ev_t e;
    e.kind = kind; e.val = val; e.up = up; e.q = q; e.gap = gap;
    sbq.push_back(e);
  endtask

  // Sweep-level reference: list every load, step and done the sweep must produce
  task automatic build_model(input int m, input int s, input int e, input int d, input int r);
    int k, pos, up;
    bit first;
    if (m == 2) begin
      push_ev(0, s, 0, 0, -1);
      pos = s; first = 1'b1; k = (e - s) & 15;
      for (int p = 0; p <= r; p++) begin
        for (int i = 0; i < k; i++) begin
          push_ev(1, pos, 1, 0, first ? 1 : d + 1); first = 1'b0; pos = (pos + 1) & 15;
        end
        if (s != e) begin
          for (int i = 0; i < k; i++) begin
            push_ev(1, pos, 0, 0, d + 1); pos = (pos - 1) & 15;
          end
        end
      end
      push_ev(2, (r + 1) & 15, 0, s, (s == e) ? -1 : 2);
    end else begin
      up = (m != 1);
      k = up ? ((e - s) & 15) : ((s - e) & 15);
      for (int p = 0; p <= r; p++) begin
        push_ev(0, s, 0, 0, (p == 0) ? -1 : 2);
        pos = s;
        for (int i = 0; i < k; i++) begin
          push_ev(1, pos, up, 0, (i == 0) ? 1 : d + 1);
          pos = up ? ((pos + 1) & 15) : ((pos - 1) & 15);
        end
      end
      push_ev(2, (r + 1) & 15, 0, e, 2);
    end
  endtask

  // Monitor: pops one expected event whenever the DUT presents load, step or done
  initial begin
    ev_t e;
    int k;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb_on && !rst && (cnt_load || cnt_enable || done)) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_event: load=%0d en=%0d done=%0d with empty queue", cnt_load, cnt_enable, done);
        end else begin
          e = sbq.pop_front();
          k = cnt_load ? 0 : (done ? 2 : 1);
          chk("event_kind", k, e.kind);
          if (e.gap >= 0) chk("event_spacing", cyc - last_cyc, e.gap);
          case (e.kind)
            0: chk("load_L", cnt_L, e.val);
            1: begin
              chk("step_q", cnt_q, e.val);
              chk("step_up", cnt_up, e.up);
              chk("busy_run", busy, 1);
            end
            default: begin
              chk("done_pass_cnt", pass_cnt, e.val);
              chk("done_err", err, 0);
              chk("done_q", cnt_q, e.q);
              chk("done_busy", busy, 0);
            end
          endcase
          last_cyc = cyc;
        end
      end
    end
  end

  task automatic run_sweep(input int m, input int s, input int e, input int d, input int r);
    int n;
    build_model(m, s, e, d, r);
    sb_on = 1'b1;
    mode = 2'(m); start_val = 4'(s); end_val = 4'(e); div = 8'(d); repeats = 4'(r);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_cleared", err, 0);
    chk("busy_on_load", busy, 1);
    mode = 2'($urandom_range(3, 0)); start_val = 4'($urandom_range(15, 0));
    end_val = 4'($urandom_range(15, 0)); div = 8'($urandom_range(7, 0));
    repeats = 4'($urandom_range(7, 0));
    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL sweep_timeout: no done within %0d cycles (mode=%0d s=%0d e=%0d)", n, m, s, e);
    end
    tick();
    tick();
    chk("queue_drained", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    int ups, downs, loads, ens, dones;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00; q_flip = 4'd0;
    start_val = 4'd0; end_val = 4'd0; div = 8'd0; repeats = 4'd0;
    tick(); tick();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_load", cnt_load, 0);
    rst = 1'b0;
    tick();

    run_sweep(0, 3, 9, 0, 0);
    run_sweep(1, 2, 14, 1, 0);
    run_sweep(2, 5, 7, 2, 1);
    run_sweep(0, 4, 6, 0, 2);
    run_sweep(0, 4, 4, 0, 0);
    run_sweep(3, 14, 1, 1, 1);
    for (int i = 0; i < 24; i++) begin
      run_sweep($urandom_range(3, 0), $urandom_range(15, 0), $urandom_range(15, 0),
                $urandom_range(3, 0), $urandom_range(3, 0));
    end

    // Abort mid-sweep with a stray start during RUN
    sb_on = 1'b0;
    mode = 2'b00; start_val = 4'd0; end_val = 4'd15; div = 8'd3; repeats = 4'd0;
    start = 1'b1; tick(); start = 1'b0;
    chk("abort_test_load", cnt_load, 1);
    ups = 0; downs = 0; loads = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 5) begin start = 1'b1; mode = 2'b01; start_val = 4'd9; end
      if (i == 6) start = 1'b0;
      tick();
      if (cnt_enable && cnt_up && !cnt_load) ups++;
      if (cnt_enable && !cnt_up) downs++;
      if (cnt_load) loads++;
    end
    chk("ignored_start_loads", loads, 0);
    chk("ignored_start_downs", downs, 0);
    chk("pulses_before_abort", ups, 4);
    chk("q_before_abort", cnt_q, 4);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_enable", cnt_enable, 0);
    chk("abort_busy", busy, 0);
    ens = 0; dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      ens += cnt_enable; dones += done;
    end
    chk("abort_no_enable", ens, 0);
    chk("abort_no_done", dones, 0);
    chk("abort_pass_hold", pass_cnt, 0);
    chk("abort_err_hold", err, 0);

    // Single-cycle Q disagreement during RUN
    mode = 2'b00; start_val = 4'd0; end_val = 4'd8; div = 8'd0; repeats = 4'd0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    q_flip = 4'd1; tick(); q_flip = 4'd0;
    chk("qerr_done", done, 1); chk("qerr_err", err, 1);
    chk("qerr_busy", busy, 0); chk("qerr_enable", cnt_enable, 0);
    tick();
    chk("qerr_done_once", done, 0); chk("qerr_err_sticky", err, 1);
    chk("qerr_idle_busy", busy, 0);
    run_sweep(0, 1, 2, 0, 0);

    // Asynchronous reset mid-sweep
    sb_on = 1'b0;
    mode = 2'b00; start_val = 4'd5; end_val = 4'd14; div = 8'd0; repeats = 4'd0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("pre_rst_busy", busy, 1); chk("pre_rst_enable", cnt_enable, 1);
    chk("pre_rst_cnt_L", cnt_L, 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0); chk("arst_done", done, 0); chk("arst_err", err, 0);
    chk("arst_enable", cnt_enable, 0); chk("arst_up", cnt_up, 0);
    chk("arst_load", cnt_load, 0); chk("arst_cnt_L", cnt_L, 0); chk("arst_pass", pass_cnt, 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_idle", busy, 0);
    run_sweep(2, 9, 11, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
